// File: rtl/chan_pkg.sv
// Shared types and constants for the noisy-channel error injector.
package chan_pkg;

  typedef enum logic [1:0] {
    MODE_CLEAN    = 2'd0,
    MODE_RANDOM   = 2'd1,
    MODE_BURST    = 2'd2,
    MODE_PERIODIC = 2'd3
  } chan_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_e;

  // Right-shift Galois tap masks for maximal-length sequences.
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [23:0] LFSR_TAPS_24 = 24'hE1_0000;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      16:      return 32'(LFSR_TAPS_16);
      24:      return 32'(LFSR_TAPS_24);
      default: return LFSR_TAPS_32;
    endcase
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    return (a > (SAT_MAX - b)) ? SAT_MAX : (a + b);
  endfunction

endpackage

// File: rtl/chan_lfsr.sv
// Galois LFSR PRNG; advances one step on each cycle with adv=1.
module chan_lfsr
  import chan_pkg::*;
#(
  parameter int unsigned          LFSR_W = 16,
  parameter logic [LFSR_W-1:0]    SEED   = LFSR_W'(16'hACE1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  output logic [LFSR_W-1:0] q
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else if (adv) begin
      q <= {1'b0, q[LFSR_W-1:1]} ^ (q[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/channel_err_inject.sv
// Configurable noisy-channel model: clean/random/burst/periodic bit flips on W-bit symbols.
// Statistics counters are built only when CHAN_STATS_EN is defined; otherwise tied to 0.
module channel_err_inject
  import chan_pkg::*;
#(
  parameter int unsigned       W      = 2,
  parameter int unsigned       LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1),
  parameter int unsigned       BL_W   = 4,
  parameter int unsigned       PER_W  = 8,
  localparam int unsigned      SEL_W  = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [W-1:0]     sym_i,
  input  logic [1:0]       mode_i,
  input  logic [7:0]       thresh_i,
  input  logic [BL_W-1:0]  burst_len_i,
  input  logic [PER_W-1:0] period_i,
  input  logic [SEL_W-1:0] bit_sel_i,
  input  logic             rand_bit_i,
  output logic             valid_o,
  output logic [W-1:0]     sym_o,
  output logic [W-1:0]     err_mask_o,
  output logic [31:0]      err_sym_cnt_o,
  output logic [31:0]      err_bit_cnt_o,
  output logic [31:0]      sym_cnt_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic              unused_lfsr;
  chan_mode_e        mode, mode_q;
  burst_state_e      state_q, state_d;
  logic [BL_W-1:0]   rem_q, rem_d;
  logic              start_c;
  logic [SEL_W-1:0]  burst_bit_q;
  logic              burst_rand_q;
  logic [PER_W-1:0]  per_cnt_q, per_eff, per_last;
  logic              per_hit;
  logic              trig;
  logic [SEL_W-1:0]  rnd_idx, sel_idx, cur_idx;
  logic [W-1:0]      mask_c;

  chan_lfsr #(.LFSR_W(LFSR_W), .SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .adv (valid_i),
    .q   (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q;
  assign mode    = chan_mode_e'(mode_i);
  assign trig    = (lfsr_q[7:0] < thresh_i);
  assign rnd_idx = SEL_W'(32'(lfsr_q[SEL_W-1:0]) % W);
  assign sel_idx = SEL_W'(32'(bit_sel_i) % W);
  assign cur_idx = rand_bit_i ? rnd_idx : sel_idx;

  // Period counter restarts whenever the previous valid symbol was in another mode.
  assign per_eff  = (mode_q == MODE_PERIODIC) ? per_cnt_q : '0;
  assign per_last = period_i - PER_W'(1);
  assign per_hit  = (period_i <= PER_W'(1)) || (per_eff == per_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    start_c = 1'b0;
    if (valid_i) begin
      if (mode != MODE_BURST) begin
        state_d = ST_IDLE;
        rem_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (trig && (burst_len_i != '0)) begin
              start_c = 1'b1;
              rem_d   = burst_len_i - BL_W'(1);
              state_d = (burst_len_i != BL_W'(1)) ? ST_BURST : ST_IDLE;
            end
          end
          ST_BURST: begin
            rem_d = rem_q - BL_W'(1);
            if (rem_q == BL_W'(1)) state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    mask_c = '0;
    case (mode)
      MODE_RANDOM:   if (trig) mask_c = W'(1) << cur_idx;
      MODE_PERIODIC: if (per_hit) mask_c = W'(1) << cur_idx;
      MODE_BURST: begin
        if (state_q == ST_BURST)
          mask_c = W'(1) << (burst_rand_q ? rnd_idx : burst_bit_q);
        else if (trig && (burst_len_i != '0))
          mask_c = W'(1) << cur_idx;
      end
      default: mask_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o      <= 1'b0;
      sym_o        <= '0;
      err_mask_o   <= '0;
      mode_q       <= MODE_CLEAN;
      per_cnt_q    <= '0;
      burst_bit_q  <= '0;
      burst_rand_q <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        sym_o      <= sym_i ^ mask_c;
        err_mask_o <= mask_c;
        mode_q     <= mode;
        if (mode == MODE_PERIODIC) per_cnt_q <= per_hit ? '0 : (per_eff + PER_W'(1));
        if (start_c) begin
          burst_bit_q  <= sel_idx;
          burst_rand_q <= rand_bit_i;
        end
      end
    end
  end

`ifdef CHAN_STATS_EN
  logic [31:0] err_sym_q, err_bit_q, sym_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sym_q <= '0;
      err_bit_q <= '0;
      sym_q     <= '0;
    end else if (valid_i) begin
      sym_q     <= sat_add(sym_q, 32'd1);
      err_sym_q <= sat_add(err_sym_q, 32'(mask_c != '0));
      err_bit_q <= sat_add(err_bit_q, 32'($countones(mask_c)));
    end
  end

  assign err_sym_cnt_o = err_sym_q;
  assign err_bit_cnt_o = err_bit_q;
  assign sym_cnt_o     = sym_q;
`else
  assign err_sym_cnt_o = '0;
  assign err_bit_cnt_o = '0;
  assign sym_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_channel_err_inject.sv
// Directed bench for channel_err_inject (default parameters, W=2, SEED=16'hACE1).
module tb_channel_err_inject;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [1:0]  sym_i = '0;
  logic [1:0]  mode_i = '0;
  logic [7:0]  thresh_i = '0;
  logic [3:0]  burst_len_i = '0;
  logic [7:0]  period_i = '0;
  logic        bit_sel_i = 1'b0;
  logic        rand_bit_i = 1'b0;
  logic        valid_o;
  logic [1:0]  sym_o, err_mask_o;
  logic [31:0] err_sym_cnt_o, err_bit_cnt_o, sym_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  channel_err_inject dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .sym_i(sym_i), .mode_i(mode_i),
    .thresh_i(thresh_i), .burst_len_i(burst_len_i), .period_i(period_i),
    .bit_sel_i(bit_sel_i), .rand_bit_i(rand_bit_i), .valid_o(valid_o), .sym_o(sym_o),
    .err_mask_o(err_mask_o), .err_sym_cnt_o(err_sym_cnt_o), .err_bit_cnt_o(err_bit_cnt_o),
    .sym_cnt_o(sym_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [1:0] sym;
    logic [1:0] mode;
    logic [7:0] thresh;
    logic       bsel;
    logic       rbit;
    logic       ev;
    logic [1:0] esym;
    logic [1:0] emask;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] st(input logic [31:0] v);
`ifdef CHAN_STATS_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  task automatic apply(input logic v, input logic [1:0] s, input logic [1:0] m,
                       input logic [7:0] th, input logic [3:0] bl, input logic [7:0] per,
                       input logic bs, input logic rb);
    valid_i = v; sym_i = s; mode_i = m; thresh_i = th;
    burst_len_i = bl; period_i = per; bit_sel_i = bs; rand_bit_i = rb;
    @(posedge clk); #1;
  endtask

  task automatic chk_out(input string name, input logic ev, input logic [1:0] es, input logic [1:0] em);
    chk({name, ".valid"}, 32'(valid_o), 32'(ev));
    chk({name, ".sym"},   32'(sym_o),   32'(es));
    chk({name, ".mask"},  32'(err_mask_o), 32'(em));
  endtask

  task automatic chk_stats(input string name, input logic [31:0] s, input logic [31:0] e);
    chk({name, ".sym_cnt"}, sym_cnt_o,     st(s));
    chk({name, ".err_sym"}, err_sym_cnt_o, st(e));
    chk({name, ".err_bit"}, err_bit_cnt_o, st(e));
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  initial begin
    logic [1:0]  s;
    logic [1:0]  em;
    logic [15:0] m;
    int          cnt;

    // LFSR low bytes from 16'hACE1: E1,70,38,9C,4E,27,13,...
    tbl[0] = '{1'b1, 2'b10, 2'd1, 8'd200, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00};
    tbl[1] = '{1'b1, 2'b11, 2'd1, 8'd200, 1'b1, 1'b0, 1'b1, 2'b01, 2'b10};
    tbl[2] = '{1'b0, 2'b00, 2'd1, 8'd255, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10};
    tbl[3] = '{1'b1, 2'b00, 2'd1, 8'd57,  1'b1, 1'b1, 1'b1, 2'b01, 2'b01};
    tbl[4] = '{1'b1, 2'b00, 2'd1, 8'd156, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
    tbl[5] = '{1'b1, 2'b11, 2'd0, 8'd255, 1'b1, 1'b0, 1'b1, 2'b11, 2'b00};
    tbl[6] = '{1'b1, 2'b00, 2'd1, 8'd255, 1'b0, 1'b1, 1'b1, 2'b10, 2'b10};
    tbl[7] = '{1'b1, 2'b01, 2'd1, 8'd0,   1'b1, 1'b0, 1'b1, 2'b01, 2'b00};

    do_reset();
    chk_out("reset", 1'b0, 2'b00, 2'b00);
    chk_stats("reset", 32'd0, 32'd0);

    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].valid, tbl[i].sym, tbl[i].mode, tbl[i].thresh, 4'd0, 8'd0, tbl[i].bsel, tbl[i].rbit);
      chk_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].esym, tbl[i].emask);
    end
    chk_stats("tbl", 32'd7, 32'd3);

    // Clean passthrough.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      s = 2'($urandom_range(3, 0));
      apply(1'b1, s, 2'd0, 8'd255, 4'd3, 8'd1, 1'b0, 1'b0);
      chk_out("clean", 1'b1, s, 2'b00);
    end
    chk_stats("clean", 32'd100, 32'd0);

    // Periodic: every 4th, then period 1, then re-entry clears the counter.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      em = (i % 4 == 3) ? 2'b01 : 2'b00;
      apply(1'b1, 2'b00, 2'd3, 8'd0, 4'd0, 8'd4, 1'b0, 1'b0);
      chk_out("per4", 1'b1, em, em);
    end
    chk_stats("per4", 32'd16, 32'd4);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 2'b00, 2'd3, 8'd0, 4'd0, 8'd1, 1'b1, 1'b0);
      chk_out("per1", 1'b1, 2'b10, 2'b10);
    end
    apply(1'b1, 2'b00, 2'd3, 8'd0, 4'd0, 8'd3, 1'b0, 1'b0);
    chk_out("per3a", 1'b1, 2'b00, 2'b00);
    apply(1'b1, 2'b00, 2'd3, 8'd0, 4'd0, 8'd3, 1'b0, 1'b0);
    chk_out("per3b", 1'b1, 2'b00, 2'b00);
    apply(1'b1, 2'b00, 2'd0, 8'd0, 4'd0, 8'd3, 1'b0, 1'b0);
    chk_out("per_clean", 1'b1, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) begin
      em = (i == 2) ? 2'b01 : 2'b00;
      apply(1'b1, 2'b00, 2'd3, 8'd0, 4'd0, 8'd3, 1'b0, 1'b0);
      chk_out("per_reentry", 1'b1, em, em);
    end

    // Burst of 3 with valid gaps; parameters changed mid-burst must not apply.
    do_reset();
    apply(1'b1, 2'b00, 2'd2, 8'd255, 4'd3, 8'd0, 1'b0, 1'b0);
    chk_out("burst1", 1'b1, 2'b01, 2'b01);
    apply(1'b0, 2'b00, 2'd2, 8'd0, 4'd7, 8'd0, 1'b1, 1'b0);
    chk_out("burst_gap1", 1'b0, 2'b01, 2'b01);
    apply(1'b0, 2'b00, 2'd2, 8'd0, 4'd7, 8'd0, 1'b1, 1'b0);
    chk_out("burst_gap2", 1'b0, 2'b01, 2'b01);
    apply(1'b1, 2'b00, 2'd2, 8'd0, 4'd7, 8'd0, 1'b1, 1'b0);
    chk_out("burst2", 1'b1, 2'b01, 2'b01);
    apply(1'b0, 2'b00, 2'd2, 8'd0, 4'd7, 8'd0, 1'b1, 1'b0);
    chk_out("burst_gap3", 1'b0, 2'b01, 2'b01);
    apply(1'b1, 2'b00, 2'd2, 8'd0, 4'd7, 8'd0, 1'b1, 1'b0);
    chk_out("burst3", 1'b1, 2'b01, 2'b01);
    apply(1'b1, 2'b00, 2'd2, 8'd0, 4'd7, 8'd0, 1'b1, 1'b0);
    chk_out("burst_end", 1'b1, 2'b00, 2'b00);
    apply(1'b1, 2'b00, 2'd2, 8'd255, 4'd7, 8'd0, 1'b1, 1'b0);
    chk_out("burst_new", 1'b1, 2'b10, 2'b10);
    apply(1'b1, 2'b00, 2'd1, 8'd0, 4'd7, 8'd0, 1'b1, 1'b0);
    chk_out("burst_leave", 1'b1, 2'b00, 2'b00);
    apply(1'b1, 2'b00, 2'd2, 8'd0, 4'd7, 8'd0, 1'b1, 1'b0);
    chk_out("burst_aborted", 1'b1, 2'b00, 2'b00);
    apply(1'b1, 2'b00, 2'd2, 8'd255, 4'd0, 8'd0, 1'b1, 1'b0);
    chk_out("burst_len0", 1'b1, 2'b00, 2'b00);

    // Reset in the middle of a 5-symbol burst, then replay from power-on state.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 2'b00, 2'd2, (i == 0) ? 8'd255 : 8'd0, 4'd5, 8'd0, 1'b1, 1'b0);
      chk_out("pre_rst", 1'b1, 2'b10, 2'b10);
    end
    rst = 1'b1;
    apply(1'b1, 2'b00, 2'd2, 8'd0, 4'd5, 8'd0, 1'b1, 1'b0);
    chk_out("mid_rst", 1'b0, 2'b00, 2'b00);
    chk_stats("mid_rst", 32'd0, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      em = (i < 5) ? 2'b10 : 2'b00;
      apply(1'b1, 2'b00, 2'd2, (i == 0) ? 8'd255 : 8'd0, 4'd5, 8'd0, 1'b1, 1'b0);
      chk_out("post_rst", 1'b1, em, em);
    end

    // Random mode, threshold 0: never triggers.
    do_reset();
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      apply(1'b1, 2'($urandom_range(3, 0)), 2'd1, 8'd0, 4'd0, 8'd0, 1'b0, 1'b1);
      if (err_mask_o != 2'b00) cnt++;
    end
    chk("rand_th0.errors", 32'(cnt), 32'd0);
    chk_stats("rand_th0", 32'd1000, 32'd0);

    // Random mode, threshold 128, against a golden LFSR.
    do_reset();
    m = 16'hACE1;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      s  = 2'($urandom_range(3, 0));
      em = (m[7:0] < 8'd128) ? 2'b10 : 2'b00;
      if (em != 2'b00) cnt++;
      m = lfsr_next(m);
      apply(1'b1, s, 2'd1, 8'd128, 4'd0, 8'd0, 1'b1, 1'b0);
      chk("rand128.mask", 32'(err_mask_o), 32'(em));
      chk("rand128.sym", 32'(sym_o), 32'(s ^ em));
    end
    chk_stats("rand128", 32'd1000, 32'(cnt));

`ifdef CHAN_STATS_EN
    // Saturation from a preloaded near-max count.
    do_reset();
    force dut.err_sym_q = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    release dut.err_sym_q;
    for (int i = 0; i < 3; i++) apply(1'b1, 2'b00, 2'd3, 8'd0, 4'd0, 8'd1, 1'b0, 1'b0);
    chk("sat.err_sym", err_sym_cnt_o, 32'hFFFF_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/channel_err_inject.md
Name: channel_err_inject

Overview:
- Parametrised noisy-channel model placed between the convolutional encoder output and the Viterbi decoder input in the tx/rx test harness.
- Generalises the fixed single-bit / double-hit injector into a configurable block:
  - W-bit symbols.
  - Four runtime modes: clean, random, burst, periodic.
  - Seeded LFSR for reproducibility.
  - Error and symbol statistics.
- Fully registered, one symbol per valid cycle.

Parameters:
- W, 2, symbol width in bits (encoder output width).
- LFSR_W, 16, PRNG width; Galois LFSR, taps from the package.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.
- BL_W, 4, width of the burst-length field; maximum burst is 2**BL_W-1 symbols.
- PER_W, 8, width of the period field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  input symbol qualifier
- sym_i  in  W  clean symbol from encoder
- mode_i  in  2  0=CLEAN, 1=RANDOM, 2=BURST, 3=PERIODIC
- thresh_i  in  8  trigger probability thresh_i/256
- burst_len_i  in  BL_W  consecutive corrupted symbols per burst
- period_i  in  PER_W  corrupt every period_i-th valid symbol
- bit_sel_i  in  $clog2(W)  bit to flip; used unless rand_bit_i=1
- rand_bit_i  in  1  1: flipped bit index = lfsr[$clog2(W)-1:0] mod W
- valid_o  out  1  output qualifier
- sym_o  out  W  possibly corrupted symbol
- err_mask_o  out  W  bits flipped in sym_o
- err_sym_cnt_o  out  32  corrupted-symbol count (stats)
- err_bit_cnt_o  out  32  flipped-bit count (stats)
- sym_cnt_o  out  32  valid-symbol count (stats)

Behaviour:
- Reset (rst=1 at a clk edge):
  - valid_o=0, sym_o=0, err_mask_o=0.
  - All counters=0, lfsr=SEED, FSM=IDLE, period counter=0.
  - Reset mid-burst aborts the burst; no residual corruption after reset.
- Latency:
  - sym_o, valid_o and err_mask_o appear exactly 1 cycle after valid_i/sym_i.
  - sym_o = sym_i ^ err_mask_o.
  - valid_i=0: valid_o=0, sym_o and err_mask_o hold their previous values, LFSR and counters hold.
- LFSR advances once per valid_i cycle, in every mode including CLEAN, so a given SEED gives the same sequence regardless of mode history.
- Trigger: trig = (lfsr[7:0] < thresh_i), evaluated on the pre-advance LFSR value. thresh_i=0 never triggers. thresh_i=255 triggers with probability 255/256.
- Flip mask: one-hot at the selected bit index. If the index is ≥ W, it wraps modulo W.
- CLEAN: mask=0, FSM forced to IDLE.
- RANDOM: mask applied when trig=1.
- BURST, FSM states IDLE and BURST, with a remaining-symbol counter rem:
  - IDLE and trig and burst_len_i≠0: corrupt the current symbol, rem=burst_len_i-1, go to BURST if rem≠0.
  - BURST: corrupt every valid symbol, decrement rem, return to IDLE when rem reaches 0.
  - burst_len_i=0: no corruption.
  - burst_len_i and the flip bit are sampled only at burst start. With rand_bit_i=1, each burst symbol takes a fresh index.
  - Triggers during BURST are ignored; bursts do not extend.
- PERIODIC:
  - Period counter increments per valid symbol; the symbol is corrupted when counter == period_i-1, then the counter wraps to 0.
  - period_i=0 or 1: every symbol is corrupted.
- Mode change:
  - Takes effect on the next valid symbol.
  - Leaving BURST mode aborts the burst (FSM to IDLE).
  - Entering PERIODIC clears the period counter.
- Counters:
  - Saturate at 32'hFFFF_FFFF; no wrap.
  - err_bit_cnt_o adds popcount(mask), always 1 or 0 in this design.

Optional Feature:
- Macro CHAN_STATS_EN.
- Defined: the three 32-bit counters are implemented as specified.
- Undefined: counters are not instantiated, and err_sym_cnt_o, err_bit_cnt_o and sym_cnt_o are tied to 0.
- Injection behaviour is identical either way.

Decomposition:
- Package chan_pkg:
  - chan_mode_e enum (CLEAN, RANDOM, BURST, PERIODIC).
  - burst_state_e (IDLE, BURST).
  - LFSR tap constants for 16/24/32 bits (16-bit: 16'hB400).
  - SAT_MAX constant.
- Sub-module chan_lfsr: parameters LFSR_W and SEED; ports clk, rst, adv, q.

Test Plan:
- mode=0, 100 valid symbols with random sym_i -> sym_o==sym_i delayed 1 cycle, err_mask_o=0 always; stats: sym_cnt_o=100, err_sym_cnt_o=0.
- mode=3, period_i=4, bit_sel_i=0, rand_bit_i=0, 16 symbols of 2'b00 -> symbols 4, 8, 12, 16 emerge as 2'b01; err_sym_cnt_o=4.
- mode=2, thresh_i=255, burst_len_i=3 -> first trigger corrupts exactly 3 consecutive valid symbols. With valid_i gaps inserted mid-burst, the burst still spans 3 valid symbols.
- mode=1, thresh_i=0, 1000 symbols -> zero errors. With thresh_i=128 and SEED=16'hACE1, the error count matches the golden LFSR model exactly.
- rst=1 asserted mid-burst (rem=2) -> next cycle valid_o=0 and counters=0. After release, the output sequence is identical to the post-power-on sequence.
- Counter preload/force to 32'hFFFF_FFFE, then 3 errors -> err_sym_cnt_o holds at 32'hFFFF_FFFF.
